// File: rtl/p_mem_pkg.sv
// Shared types and helpers for the processor data RAM and its readout sequencer.
// Byte selection is centralised so the stream order is defined in one place.
package p_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } dump_state_t;

  localparam int BYTES = 32 / 8;
  localparam int AW    = $clog2(256);
  localparam int MAX_W = 1024;

  // idx counts transmission order; big_endian picks MSB-first
  function automatic logic [7:0] byte_sel(
    input logic [MAX_W-1:0] word,
    input int unsigned      idx,
    input int unsigned      nbytes,
    input bit               big_endian
  );
    int unsigned pos;
    pos = big_endian ? (nbytes - 1 - idx) : idx;
    return word[8*pos +: 8];
  endfunction

endpackage

// File: rtl/p_ram_core.sv
// Word array with byte-lane writes and two combinational read ports:
// one for the processor load/store path, one for the readout sequencer.
module p_ram_core
  import p_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] p_idx,
  input  logic [DATA_W-1:0]        wd,
  output logic [DATA_W-1:0]        p_rdata,
  input  logic [$clog2(DEPTH)-1:0] s_idx,
  output logic [DATA_W-1:0]        s_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[p_idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  assign p_rdata = mem_q[p_idx];
  assign s_rdata = mem_q[s_idx];

endmodule

// File: rtl/p_ram_dump.sv
// Processor data RAM with an end-of-program readout sequencer that
// streams a fixed window of words out one byte at a time.
module p_ram_dump
  import p_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 16,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd,
  input  logic                end_flag,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                dump_busy,
  output logic                dump_done
);

  localparam int NB  = DATA_W / 8;
  localparam int AWL = $clog2(DEPTH);
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WLW = $clog2(DUMP_WORDS + 1);

  dump_state_t        state_q, state_d;
  logic               end_q, end_d;
  logic [AWL-1:0]     ptr_q, ptr_d;
  logic [WLW-1:0]     wl_q, wl_d;
  logic [BIW-1:0]     bidx_q, bidx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [AWL-1:0]     p_idx;
  logic [DATA_W-1:0]  seq_rdata;
  logic               unused_addr;

  assign p_idx       = addr[AWL+1:2];
  assign unused_addr = ^{addr[31:AWL+2], addr[1:0]};

  p_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .we      (we),
    .be      (be),
    .p_idx   (p_idx),
    .wd      (wd),
    .p_rdata (rd),
    .s_idx   (ptr_q),
    .s_rdata (seq_rdata)
  );

  always_comb begin
    state_d   = state_q;
    end_d     = end_flag;
    ptr_d     = ptr_q;
    wl_d      = wl_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    out_valid = 1'b0;
    out_data  = 8'h00;
    dump_busy = 1'b0;
    dump_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (end_flag && !end_q) begin
          state_d = LOAD;
          ptr_d   = AWL'(DUMP_BASE % DEPTH);
          wl_d    = WLW'(DUMP_WORDS);
        end
      end
      LOAD: begin
        dump_busy = 1'b1;
        shreg_d   = seq_rdata;
        bidx_d    = '0;
        state_d   = SEND;
      end
      SEND: begin
        dump_busy = 1'b1;
        out_valid = 1'b1;
        out_data  = byte_sel(MAX_W'(shreg_q), 32'(bidx_q),
                             NB, BIG_ENDIAN != 0);
        if (out_ready) begin
          if (bidx_q == BIW'(NB - 1)) begin
            if (wl_q == WLW'(1)) begin
              state_d = DONE;
            end else begin
              wl_d    = wl_q - WLW'(1);
              ptr_d   = ptr_q + AWL'(1);
              state_d = LOAD;
            end
          end else begin
            bidx_d = bidx_q + BIW'(1);
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        if (!end_flag) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      end_q   <= 1'b0;
      ptr_q   <= '0;
      wl_q    <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      ptr_q   <= ptr_d;
      wl_q    <= wl_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_p_ram_dump.sv
// Bench for p_ram_dump: three configurations sharing one write/handshake bus,
// each checked against a word-array model and expected byte queues.
module tb_p_ram_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        end_flag;
  logic        out_ready;

  logic [31:0] rd   [3];
  logic [7:0]  od   [3];
  logic        ov   [3];
  logic        busy [3];
  logic        dn   [3];

  logic [31:0] m256 [256];
  logic [31:0] m16  [16];
  logic [7:0]  expq [3][$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: LE, base 0, 2 words; 1: BE, 1 word; 2: DEPTH 16, base 15, 2 words
  p_ram_dump #(.DATA_W(32), .DEPTH(256), .DUMP_BASE(0),
               .DUMP_WORDS(2), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .reset(reset), .we(we), .be(be), .addr(addr),
    .wd(wd), .rd(rd[0]), .end_flag(end_flag), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(out_ready),
    .dump_busy(busy[0]), .dump_done(dn[0]));

  p_ram_dump #(.DATA_W(32), .DEPTH(256), .DUMP_BASE(0),
               .DUMP_WORDS(1), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .reset(reset), .we(we), .be(be), .addr(addr),
    .wd(wd), .rd(rd[1]), .end_flag(end_flag), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(out_ready),
    .dump_busy(busy[1]), .dump_done(dn[1]));

  p_ram_dump #(.DATA_W(32), .DEPTH(16), .DUMP_BASE(15),
               .DUMP_WORDS(2), .BIG_ENDIAN(0)) u_wr (
    .clk(clk), .reset(reset), .we(we), .be(be), .addr(addr),
    .wd(wd), .rd(rd[2]), .end_flag(end_flag), .out_data(od[2]),
    .out_valid(ov[2]), .out_ready(out_ready),
    .dump_busy(busy[2]), .dump_done(dn[2]));

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        m256[a[9:2]][8*i +: 8] = d[8*i +: 8];
        m16[a[5:2]][8*i +: 8]  = d[8*i +: 8];
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    @(posedge clk);
    #1 we = 1'b1; addr = a; wd = d; be = b;
    @(posedge clk);
    model_write(a, d, b);
    #1 we = 1'b0;
  endtask

  task automatic build_exp();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) expq[k].delete();
    for (int n = 0; n < 2; n++) begin
      w = m256[n];
      for (int i = 0; i < 4; i++) expq[0].push_back(w[8*i +: 8]);
    end
    w = m256[0];
    for (int i = 0; i < 4; i++) expq[1].push_back(w[8*(3-i) +: 8]);
    for (int n = 0; n < 2; n++) begin
      w = m16[(15 + n) % 16];
      for (int i = 0; i < 4; i++) expq[2].push_back(w[8*i +: 8]);
    end
  endtask

  task automatic read_chk(input logic [31:0] a);
    addr = a;
    #1;
    total++;
    if (rd[0] !== m256[a[9:2]] || rd[1] !== m256[a[9:2]]
        || rd[2] !== m16[a[5:2]]) begin
      bad++;
      $display("FAIL read a=%h got %h/%h/%h want %h/%h", a, rd[0],
               rd[1], rd[2], m256[a[9:2]], m16[a[5:2]]);
    end
  endtask

  // mode 0: ready=1; 1: random ready; 2: ready low for cycles 3..5
  task automatic run_dump(input int mode);
    int          c;
    int          first_v [3];
    int          done_c  [3];
    int          nw      [3];
    bit          pv      [3];
    logic [7:0]  pd      [3];
    logic [7:0]  e;
    bit          pr;
    int          want;
    nw[0] = 2; nw[1] = 1; nw[2] = 2;
    build_exp();
    for (int k = 0; k < 3; k++) begin
      first_v[k] = -1; done_c[k] = -1; pv[k] = 1'b0; pd[k] = '0;
    end
    pr = 1'b0;
    @(posedge clk);
    #1 end_flag = 1'b1;
    c = 0;
    while (c < 300 && !(done_c[0] >= 0 && done_c[1] >= 0
                        && done_c[2] >= 0)) begin
      @(posedge clk);
      c++;
      #1;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_c[k] < 0) begin
          if (c == 1) begin
            total++;
            if (ov[k] !== 1'b0 || busy[k] !== 1'b1) begin
              bad++;
              $display("FAIL load_bubble inst=%0d valid=%b busy=%b want 0/1",
                       k, ov[k], busy[k]);
            end
          end
          if (pv[k] && !pr) begin
            total++;
            if (ov[k] !== 1'b1 || od[k] !== pd[k]) begin
              bad++;
              $display("FAIL hold inst=%0d valid=%b data=%h want 1/%h",
                       k, ov[k], od[k], pd[k]);
            end
          end
          if (ov[k] === 1'b1) begin
            if (first_v[k] < 0) first_v[k] = c;
            if (busy[k] !== 1'b1) begin
              total++; bad++;
              $display("FAIL busy_send inst=%0d busy=%b want 1", k, busy[k]);
            end
            if (out_ready) begin
              total++;
              if (expq[k].size() == 0) begin
                bad++;
                $display("FAIL extra_byte inst=%0d got %h want none", k, od[k]);
              end else begin
                e = expq[k].pop_front();
                if (od[k] !== e) begin
                  bad++;
                  $display("FAIL byte inst=%0d got %h want %h", k, od[k], e);
                end
              end
            end
          end
          if (dn[k] === 1'b1) done_c[k] = c;
          pv[k] = (ov[k] === 1'b1);
          pd[k] = od[k];
        end
      end
      pr = out_ready;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (done_c[k] < 0 || expq[k].size() != 0) begin
        bad++;
        $display("FAIL complete inst=%0d done_cycle=%0d left=%0d want done/0",
                 k, done_c[k], expq[k].size());
      end
      if (mode != 1) begin
        want = 1 + nw[k] * 5 + ((mode == 2) ? 3 : 0);
        total++;
        if (first_v[k] != 2 || done_c[k] != want) begin
          bad++;
          $display("FAIL timing inst=%0d first=%0d done=%0d want 2/%0d",
                   k, first_v[k], done_c[k], want);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (dn[k] !== 1'b1 || busy[k] !== 1'b0 || ov[k] !== 1'b0) begin
        bad++;
        $display("FAIL done_hold inst=%0d done=%b busy=%b valid=%b want 1/0/0",
                 k, dn[k], busy[k], ov[k]);
      end
    end
    @(posedge clk);
    #1 end_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (dn[k] !== 1'b0) begin
        bad++;
        $display("FAIL done_clear inst=%0d done=%b want 0", k, dn[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; we = 1'b0; be = '0; addr = '0; wd = '0;
    end_flag = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ov[k] !== 1'b0 || od[k] !== 8'h00 || busy[k] !== 1'b0
          || dn[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset inst=%0d v=%b d=%h b=%b dn=%b want 0", k,
                 ov[k], od[k], busy[k], dn[k]);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) wr(32'(i * 4), $urandom, 4'hf);
  endtask

  task automatic test_byte_lane();
    wr(32'h8, 32'h11223344, 4'hf);
    @(posedge clk);
    #1 we = 1'b1; addr = 32'h8; wd = 32'h0000AA00; be = 4'b0010;
    #1;
    total++;
    if (rd[0] !== 32'h11223344) begin
      bad++;
      $display("FAIL write_early got %h want 11223344", rd[0]);
    end
    @(posedge clk);
    model_write(32'h8, 32'h0000AA00, 4'b0010);
    #1 we = 1'b0;
    #1;
    total++;
    if (rd[0] !== 32'h1122AA44) begin
      bad++;
      $display("FAIL byte_lane got %h want 1122aa44", rd[0]);
    end
    read_chk(32'h8);
  endtask

  task automatic test_random_rw();
    logic [31:0] a [8];
    for (int i = 0; i < 8; i++) begin
      a[i] = {22'd0, 8'($urandom), 2'b00};
      wr(a[i], $urandom, 4'($urandom));
    end
    be = 4'hf; wd = $urandom;
    for (int i = 0; i < 8; i++) read_chk(a[i]);
    for (int i = 0; i < 4; i++) read_chk($urandom);
  endtask

  task automatic test_dump_ready();
    wr(32'h0, 32'h04030201, 4'hf);
    wr(32'h4, 32'h08070605, 4'hf);
    run_dump(0);
  endtask

  task automatic test_backpressure();
    wr(32'h0, $urandom, 4'hf);
    run_dump(2);
  endtask

  task automatic test_random_ready();
    wr(32'h4, $urandom, 4'hf);
    wr(32'h3c, $urandom, 4'hf);
    run_dump(1);
  endtask

  task automatic test_big_endian();
    wr(32'h0, 32'hDEADBEEF, 4'hf);
    run_dump(0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1 end_flag = 1'b1; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0; end_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ov[k] !== 1'b0 || busy[k] !== 1'b0 || dn[k] !== 1'b0
          || od[k] !== 8'h00) begin
        bad++;
        $display("FAIL reset_mid inst=%0d v=%b b=%b dn=%b d=%h want 0",
                 k, ov[k], busy[k], dn[k], od[k]);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    read_chk(32'h0);
    read_chk(32'h4);
    read_chk(32'h3c);
    run_dump(0);
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_byte_lane();
    test_random_rw();
    test_dump_ready();
    test_backpressure();
    test_random_ready();
    test_big_endian();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_ram_dump.md
# p_ram_dump

Parametrised successor to the processor data memory: a word-addressed, byte-lane-writable RAM serving the pipelined processor's load/store port with combinational read, plus an integrated readout sequencer. When the processor raises its end flag, the sequencer streams a configured window of memory out one byte at a time over a valid/ready handshake. The narrow pin-level result output is driven from this stream. Sits between the processor's memory port and the FPGA output pins.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 256, number of words; power of two
- DUMP_BASE, 0, first word index streamed
- DUMP_WORDS, 16, number of words streamed; 1..DEPTH
- BIG_ENDIAN, 0, 0 = byte 0 (bits 7:0) sent first; 1 = MSB byte sent first

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- we  in  1  processor write enable
- be  in  DATA_W/8  byte-lane write enables
- addr  in  32  processor byte address; word index = addr[log2(DEPTH)+1:2], upper bits ignored
- wd  in  DATA_W  write data
- rd  out  DATA_W  read data, combinational from addr
- end_flag  in  1  processor program-finished level
- out_data  out  8  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- dump_busy  out  1  sequencer active (LOAD or SEND)
- dump_done  out  1  window fully streamed

## Operation
- Write: on rising clk with we=1, each lane i with be[i]=1 updates byte i of mem[word index]; lanes with be[i]=0 are unchanged. we=0 ignores be.
- Read: rd = mem[word index] combinationally. A same-cycle write is visible only after the edge.
- Reset clears sequencer state and outputs. It does not clear memory contents.
- end_flag edge detect: end_q is a registered copy of end_flag. A start event is end_flag=1 && end_q=0.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: start event -> LOAD; ptr=DUMP_BASE, words_left=DUMP_WORDS.
  - LOAD: shreg <= mem[ptr]; byte_idx=0; -> SEND. No output this cycle.
  - SEND: out_valid=1. out_data = byte byte_idx of shreg, in the order set by BIG_ENDIAN. On out_valid && out_ready, advance byte_idx.
    - Last byte of a word accepted, more words left: ptr=(ptr+1) mod DEPTH, -> LOAD.
    - Last byte of the last word accepted: -> DONE.
  - DONE: dump_done=1. Returns to IDLE when end_flag=0.
- Pointer wraps modulo DEPTH, so DUMP_BASE+DUMP_WORDS may exceed DEPTH.
- Processor writes remain allowed during a dump. A word's content is fixed at its LOAD cycle. A write in the same cycle as LOAD to that word is not captured (old data streamed).
- end_flag deasserting during LOAD/SEND does not abort the dump. DONE is then left on the next cycle.
- A start event is only accepted in IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, dump_busy=0, dump_done=0, state=IDLE, end_q=0. rd follows memory.
- Start event at edge N -> LOAD in cycle N+1 -> first out_valid in cycle N+2.
- With out_ready held at 1: each word takes DATA_W/8 + 1 cycles (one LOAD bubble). A 32-bit word takes 5 cycles.
- out_data must hold stable while out_valid=1 and out_ready=0. out_valid never drops without an acceptance, except on reset.
- dump_busy=1 exactly in LOAD and SEND.
- dump_done rises the cycle after the final accept and holds while end_flag=1.
- Reset asserted mid-dump: state, outputs and counters return to reset values at the next edge. A new start event requires end_flag to fall and rise again.

## Structure
- Shared package p_mem_pkg:
  - dump_state_t enum (IDLE, LOAD, SEND, DONE)
  - localparams BYTES = DATA_W/8 and AW = $clog2(DEPTH)
  - helper function byte_sel(word, idx, big_endian)
- One sub-module: p_ram_core. It holds the array, byte-lane write and two combinational read ports (processor, sequencer).
- p_ram_dump contains the FSM, pointer and counters, shift register, and edge detector.

## Test plan
- Byte-lane write: write 0x11223344 with be=1111, then 0xAA with be=0010 to addr 0x8 -> rd at 0x8 = 0x1122AA44.
- Dump, ready=1: DUMP_BASE=0, DUMP_WORDS=2, mem[0]=0x04030201, mem[1]=0x08070605, raise end_flag -> bytes 01..08 on consecutive valid cycles, one bubble between words, dump_done 1 cycle after byte 08.
- Backpressure: hold out_ready=0 for 3 cycles mid-word -> out_data and out_valid stable, no byte lost or duplicated.
- BIG_ENDIAN=1, mem[0]=0xDEADBEEF, DUMP_WORDS=1 -> stream DE, AD, BE, EF.
- Wrap: DEPTH=16, DUMP_BASE=15, DUMP_WORDS=2 -> streams mem[15] then mem[0].
- Reset mid-SEND -> out_valid=0, dump_busy=0 next cycle, memory intact. Toggling end_flag 0->1 restarts the dump from DUMP_BASE.
